// File: rtl/cmd_frame_initiator.sv
// Host-side UART command initiator: serialises one command into a TX byte frame and assembles the RX response.
// Optional response timeout is built only when CMD_TIMEOUT_EN is defined.
module cmd_frame_initiator #(
  parameter int                          frame_data_width            = 8,
  parameter int                          data_width                  = 16,
  parameter int                          addr_width                  = 4,
  parameter int                          function_width              = 4,
  parameter logic [frame_data_width-1:0] register_file_write_command = 8'hAA,
  parameter logic [frame_data_width-1:0] register_file_read_command  = 8'hBB,
  parameter logic [frame_data_width-1:0] ALU_with_op_command         = 8'hCC,
  parameter logic [frame_data_width-1:0] ALU_without_op_command      = 8'hDD,
  parameter int                          TIMEOUT_CYCLES              = 1024
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CMD_VLD,
  input  logic [1:0]                  CMD_TYPE,
  input  logic [addr_width-1:0]       CMD_ADDR,
  input  logic [frame_data_width-1:0] CMD_WDATA,
  input  logic [frame_data_width-1:0] CMD_OPA,
  input  logic [frame_data_width-1:0] CMD_OPB,
  input  logic [function_width-1:0]   CMD_FUN,
  output logic                        CMD_BUSY,
  output logic [frame_data_width-1:0] TX_P_DATA,
  output logic                        TX_D_VLD,
  input  logic                        TX_READY,
  input  logic [frame_data_width-1:0] RX_P_DATA,
  input  logic                        RX_D_VLD,
  output logic [data_width-1:0]       RSP_DATA,
  output logic                        RSP_VLD,
  output logic                        RSP_TIMEOUT
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_RSP, ST_DONE} state_t;

  localparam logic [1:0] TYP_WR  = 2'b00;
  localparam logic [1:0] TYP_RD  = 2'b01;
  localparam logic [1:0] TYP_ALU = 2'b10;

  function automatic logic [frame_data_width-1:0] frame_byte(
    input logic [1:0]                  typ,
    input logic [1:0]                  idx,
    input logic [addr_width-1:0]       addr,
    input logic [frame_data_width-1:0] wdata,
    input logic [frame_data_width-1:0] opa,
    input logic [frame_data_width-1:0] opb,
    input logic [function_width-1:0]   fun
  );
    logic [frame_data_width-1:0] addr_x;
    logic [frame_data_width-1:0] fun_x;
    logic [frame_data_width-1:0] b;
    addr_x = {{(frame_data_width-addr_width){1'b0}}, addr};
    fun_x  = {{(frame_data_width-function_width){1'b0}}, fun};
    b      = {frame_data_width{1'b0}};
    case (typ)
      2'b00: begin
        case (idx)
          2'd0:    b = register_file_write_command;
          2'd1:    b = addr_x;
          2'd2:    b = wdata;
          default: b = {frame_data_width{1'b0}};
        endcase
      end
      2'b01: begin
        case (idx)
          2'd0:    b = register_file_read_command;
          2'd1:    b = addr_x;
          default: b = {frame_data_width{1'b0}};
        endcase
      end
      2'b10: begin
        case (idx)
          2'd0:    b = ALU_with_op_command;
          2'd1:    b = opa;
          2'd2:    b = opb;
          default: b = fun_x;
        endcase
      end
      default: begin
        case (idx)
          2'd0:    b = ALU_without_op_command;
          2'd1:    b = fun_x;
          default: b = {frame_data_width{1'b0}};
        endcase
      end
    endcase
    return b;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] typ);
    logic [1:0] l;
    case (typ)
      2'b00:   l = 2'd2;
      2'b01:   l = 2'd1;
      2'b10:   l = 2'd3;
      default: l = 2'd1;
    endcase
    return l;
  endfunction

  state_t                      state_q, state_d;
  logic                        busy_q, busy_d;
  logic [frame_data_width-1:0] tx_data_q, tx_data_d;
  logic                        tx_vld_q, tx_vld_d;
  logic [data_width-1:0]       rsp_data_q, rsp_data_d;
  logic                        rsp_vld_q, rsp_vld_d;
  logic [1:0]                  typ_q, typ_d;
  logic [addr_width-1:0]       addr_q, addr_d;
  logic [frame_data_width-1:0] wdata_q, wdata_d;
  logic [frame_data_width-1:0] opa_q, opa_d;
  logic [frame_data_width-1:0] opb_q, opb_d;
  logic [function_width-1:0]   fun_q, fun_d;
  logic [1:0]                  idx_q, idx_d;
  logic                        rsp_idx_q, rsp_idx_d;
  logic [frame_data_width-1:0] shadow_q, shadow_d;
`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value from which one more idle cycle reaches TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        to_q, to_d;
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = tx_vld_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = 1'b0;
    typ_d      = typ_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    fun_d      = fun_q;
    idx_d      = idx_q;
    rsp_idx_d  = rsp_idx_q;
    shadow_d   = shadow_q;
`ifdef CMD_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (CMD_VLD) begin
          typ_d     = CMD_TYPE;
          addr_d    = CMD_ADDR;
          wdata_d   = CMD_WDATA;
          opa_d     = CMD_OPA;
          opb_d     = CMD_OPB;
          fun_d     = CMD_FUN;
          idx_d     = 2'd0;
          tx_data_d = frame_byte(CMD_TYPE, 2'd0, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUN);
          tx_vld_d  = 1'b1;
          state_d   = ST_SEND;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tx_vld_q && TX_READY) begin
          if (idx_q == last_idx(typ_q)) begin
            tx_vld_d = 1'b0;
            if (typ_q == TYP_WR) begin
              state_d    = ST_DONE;
              rsp_vld_d  = 1'b1;
              rsp_data_d = {data_width{1'b0}};
            end else begin
              state_d    = ST_WAIT_RSP;
              rsp_idx_d  = 1'b0;
`ifdef CMD_TIMEOUT_EN
              cnt_d      = {CNT_W{1'b0}};
`endif
            end
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = frame_byte(typ_q, idx_q + 2'd1, addr_q, wdata_q, opa_q, opb_q, fun_q);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_RSP: begin
        // A byte arriving on the limit cycle wins over the timeout.
        if (RX_D_VLD) begin
`ifdef CMD_TIMEOUT_EN
          cnt_d = {CNT_W{1'b0}};
`endif
          if (typ_q == TYP_RD) begin
            state_d    = ST_DONE;
            rsp_vld_d  = 1'b1;
            rsp_data_d = {{(data_width-frame_data_width){1'b0}}, RX_P_DATA};
          end else if (rsp_idx_q) begin
            state_d    = ST_DONE;
            rsp_vld_d  = 1'b1;
            rsp_data_d = {RX_P_DATA, shadow_q};
          end else begin
            shadow_d   = RX_P_DATA;
            rsp_idx_d  = 1'b1;
          end
        end else begin
`ifdef CMD_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            to_d    = 1'b1;
          end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = ST_WAIT_RSP;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        tx_vld_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      tx_data_q  <= {frame_data_width{1'b0}};
      tx_vld_q   <= 1'b0;
      rsp_data_q <= {data_width{1'b0}};
      rsp_vld_q  <= 1'b0;
      typ_q      <= TYP_WR;
      addr_q     <= {addr_width{1'b0}};
      wdata_q    <= {frame_data_width{1'b0}};
      opa_q      <= {frame_data_width{1'b0}};
      opb_q      <= {frame_data_width{1'b0}};
      fun_q      <= {function_width{1'b0}};
      idx_q      <= 2'd0;
      rsp_idx_q  <= 1'b0;
      shadow_q   <= {frame_data_width{1'b0}};
`ifdef CMD_TIMEOUT_EN
      cnt_q      <= {CNT_W{1'b0}};
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      typ_q      <= typ_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      fun_q      <= fun_d;
      idx_q      <= idx_d;
      rsp_idx_q  <= rsp_idx_d;
      shadow_q   <= shadow_d;
`ifdef CMD_TIMEOUT_EN
      cnt_q      <= cnt_d;
      to_q       <= to_d;
`endif
    end
  end

  assign CMD_BUSY  = busy_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_VLD   = rsp_vld_q;
`ifdef CMD_TIMEOUT_EN
  assign RSP_TIMEOUT = to_q;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/cmd_frame_initiator.md
Name: cmd_frame_initiator

Overview:
- Host-side initiator for the UART command protocol.
- Serialises one command request into a byte frame for the UART TX path: register-file write (0xAA), register-file read (0xBB), ALU with operands (0xCC), ALU without operands (0xDD).
- Collects the response bytes returned over the UART RX path and presents them as one 16-bit result.
- Used by the test host and by the loopback/self-test harness that drives the system controller.

Parameters:
- frame_data_width, 8, byte width on TX/RX paths
- data_width, 16, assembled response width
- addr_width, 4, register-file address width
- function_width, 4, ALU function code width
- register_file_write_command, 8'hAA, write opcode byte
- register_file_read_command, 8'hBB, read opcode byte
- ALU_with_op_command, 8'hCC, ALU-with-operands opcode byte
- ALU_without_op_command, 8'hDD, ALU-without-operands opcode byte
- TIMEOUT_CYCLES, 1024, idle cycles allowed between response bytes (minimum 2)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-low
- CMD_VLD  in  1  command request strobe
- CMD_TYPE  in  2  command select: 00 write, 01 read, 10 ALU with operands, 11 ALU without operands
- CMD_ADDR  in  addr_width  register address
- CMD_WDATA  in  frame_data_width  write data
- CMD_OPA  in  frame_data_width  operand A
- CMD_OPB  in  frame_data_width  operand B
- CMD_FUN  in  function_width  ALU function
- CMD_BUSY  out  1  high whenever state is not IDLE
- TX_P_DATA  out  frame_data_width  byte to transmitter
- TX_D_VLD  out  1  byte valid
- TX_READY  in  1  transmitter accepts byte
- RX_P_DATA  in  frame_data_width  received byte
- RX_D_VLD  in  1  one-cycle received-byte strobe
- RSP_DATA  out  data_width  assembled response
- RSP_VLD  out  1  one-cycle completion pulse
- RSP_TIMEOUT  out  1  one-cycle timeout pulse

Behaviour:
- Clock and reset:
  - Single clock CLK. Reset is synchronous and active-low on RST.
  - Outputs at reset: CMD_BUSY=0, TX_P_DATA=8'h00, TX_D_VLD=0, RSP_DATA=16'h0000, RSP_VLD=0, RSP_TIMEOUT=0.
  - All outputs are registered.
- State machine: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - When CMD_VLD=1, latch all CMD_* fields, load the first frame byte into TX_P_DATA, set TX_D_VLD=1, and go to SEND.
  - TX_D_VLD is therefore high in the cycle after acceptance.
  - CMD_VLD is ignored in every other state.
- Frame contents, sent in order:
  - write: AA, zero-extended addr, wdata
  - read: BB, zero-extended addr
  - ALU with operands: CC, A, B, zero-extended fun
  - ALU without operands: DD, zero-extended fun
- SEND:
  - A byte transfers on a cycle where TX_D_VLD=1 and TX_READY=1; the next byte is presented on the following cycle.
  - While TX_READY=0, TX_P_DATA and TX_D_VLD hold stable.
  - A 2-bit byte index counts transfers.
  - After the last byte transfers, TX_D_VLD drops to 0.
  - Write then goes to DONE. All other commands go to WAIT_RSP with the response counter and timeout counter cleared.
- WAIT_RSP:
  - Read expects 1 byte; RSP_DATA={8'h00, byte}.
  - ALU commands expect 2 bytes, low byte first; RSP_DATA={second, first}.
  - Incoming bytes go into an internal shadow register. RSP_DATA updates only on entry to DONE.
  - Each RX_D_VLD clears the timeout counter. After the final byte, go to DONE.
- DONE:
  - Lasts exactly one cycle with RSP_VLD=1, then returns to IDLE.
  - For write, RSP_DATA=16'h0000.
  - CMD_BUSY is 0 in the cycle after DONE; back-to-back commands are accepted from then on.
- Timeout:
  - The counter increments every WAIT_RSP cycle without RX_D_VLD.
  - When it reaches TIMEOUT_CYCLES-1, pulse RSP_TIMEOUT for one cycle and return to IDLE.
  - Partial bytes are discarded and RSP_DATA keeps its previous value.
- Boundary cases:
  - RX_D_VLD outside WAIT_RSP is ignored.
  - RX_D_VLD on the same cycle the counter hits its limit counts as a byte; no timeout fires.
  - RST low at any point (mid-frame, mid-wait): the next edge forces IDLE and all reset values, and TX_D_VLD drops immediately.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: timeout counter and RSP_TIMEOUT behave as above.
- Undefined: no counter is built, WAIT_RSP waits indefinitely, and RSP_TIMEOUT is tied to 0.

Test Plan:
- Write, TX_READY=1: CMD_TYPE=00, ADDR=4'h5, WDATA=8'h3C accepted at cycle k -> TX bytes AA,05,3C on k+1..k+3; RSP_VLD at k+4 with RSP_DATA=0000; CMD_BUSY low at k+5.
- Read with backpressure: TX_READY low 3 cycles during byte 2 -> TX_P_DATA holds 8'h05. Then RX byte 8'h7E -> RSP_VLD with RSP_DATA=16'h007E.
- ALU with operands: A=12, B=34, FUN=2 -> TX bytes CC,12,34,02; RX bytes 46 then 00 -> RSP_DATA=16'h0046, one RSP_VLD pulse.
- ALU without operands, one response byte only (macro defined, TIMEOUT_CYCLES=16) -> RSP_TIMEOUT pulse 15 cycles after the last RX byte, RSP_DATA unchanged, state back in IDLE; CMD_VLD during WAIT_RSP ignored.
- Reset mid-SEND of ALU-with-operands after byte 2 -> TX_D_VLD=0 and CMD_BUSY=0 on the next edge. A new read command then produces the correct BB frame.
- Stray RX_D_VLD in IDLE plus CMD_VLD held high across DONE -> stray byte ignored; second command accepted only once CMD_BUSY=0.
